seg7_scan_ctrl: RTL



---
 rtl/seg7_scan_ctrl_if.sv | 21 ++
 rtl/seg7_scan_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// Display bus between the value source and the 7-segment scan controller.
// Carries the value/blank/load inputs and the scan outputs.
interface seg7_scan_ctrl_if;
  logic [15:0] value;
  logic [3:0]  blank;
  logic        load;
  logic [1:0]  digit_sel;
  logic [3:0]  nibble;
  logic        seg_en;
  logic        frame_done;

  modport master (
    output value, blank, load,
    input  digit_sel, nibble, seg_en, frame_done
  );

  modport slave (
    input  value, blank, load,
    output digit_sel, nibble, seg_en, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 4-digit 7-segment scan controller, double-buffered display value.
// Optional leading-zero suppression: define SEG7_LZ_SUPPRESS_EN.
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2000
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_ctrl_if.slave   bus
);

  localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] GRD  = DW'(GUARD);

  logic [DW-1:0] div_cnt;
  logic [1:0]    digit_sel;
  logic [15:0]   shadow_val;
  logic [3:0]    shadow_blank;
  logic [15:0]   pending_val;
  logic [3:0]    pending_blank;
  logic          pending_v;
  logic          frame_done;
  logic [3:0]    lz_blank;
  logic          tick;
  logic          boundary;

  assign tick     = (div_cnt == LAST);
  assign boundary = tick && (digit_sel == 2'd3);

  // Slot prescaler and digit select
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      digit_sel <= 2'd0;
    end else if (tick) begin
      div_cnt   <= '0;
      digit_sel <= digit_sel + 2'd1;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
    end
  end

  // Pending/shadow double buffer, swapped only at frame boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_val    <= '0;
      shadow_blank  <= '0;
      pending_val   <= '0;
      pending_blank <= '0;
      pending_v     <= 1'b0;
    end else if (boundary) begin
      pending_v <= 1'b0;
      if (bus.load) begin
        shadow_val    <= bus.value;
        shadow_blank  <= bus.blank;
        pending_val   <= bus.value;
        pending_blank <= bus.blank;
      end else if (pending_v) begin
        shadow_val    <= pending_val;
        shadow_blank  <= pending_blank;
      end
    end else if (bus.load) begin
      pending_val   <= bus.value;
      pending_blank <= bus.blank;
      pending_v     <= 1'b1;
    end
  end

  // Frame-done pulse one cycle after the boundary
  always_ff @(posedge clk) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= boundary;
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  // Suppress digits that are zero along with every higher digit
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (shadow_val[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (shadow_val[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (shadow_val[7:4] == 4'd0);
  end
`else
  assign lz_blank = 4'b0000;
`endif

  assign bus.digit_sel  = digit_sel;
  assign bus.nibble     = shadow_val[{digit_sel, 2'b00} +: 4];
  assign bus.seg_en     = (div_cnt >= GRD)
                       && !shadow_blank[digit_sel]
                       && !lz_blank[digit_sel];
  assign bus.frame_done = frame_done;

endmodule
